pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central sequencing and hazard controller for the 5-stage CPU pipeline (IFetch → IFID → IDEX → EXMEM → MEMWB). It gates execution with a run/drain/halt state machine and inserts load-use stalls. It also squashes wrong-path instructions after a taken branch. The CPU top wires its outputs to the PC enable and to the IFID/IDEX/EXMEM enable and flush inputs.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN after a halt, for older instructions to retire. Legal range 1–15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `cpuclk`, in, 1: CPU clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: run request (level).
- `upg_done_i`, in, 1: 1 = program load finished, memories valid.
- `halt_i`, in, 1: instruction in ID decodes as halt (ecall).
- `id_rs1`, `id_rs2`, in, 5 each: source registers of the instruction in ID.
- `ex_rd`, in, 5: destination register in IDEX.
- `ex_memread`, in, 1: MemRead of the instruction in IDEX.
- `pcsrc`, in, 1: taken branch resolved at EXMEM output.
- `pc_en`, out, 1: PC update enable.
- `ifid_en`, out, 1: IFID hold when 0.
- `ifid_flush`, `idex_flush`, `exmem_flush`, out, 1 each: load a bubble (all control bits 0) on the next edge.
- `state_o`, out, 2: IDLE=00, RUN=01, DRAIN=10, HALT=11.
- `cycle_cnt`, `stall_cnt`, `flush_cnt`, out, CNT_W each: performance counters (see Configuration).

## Operation
State transitions:
- IDLE→RUN when `start & upg_done_i`.
- RUN→DRAIN when `halt_i & ~pcsrc`. The drain counter loads DRAIN_CYCLES−1.
- RUN→IDLE when `~upg_done_i`, which means reprogramming started. This takes priority over halt.
- DRAIN→RUN when `pcsrc`: the halt was on the wrong path and is squashed.
- DRAIN→HALT when the drain counter reaches 0 and `pcsrc` is 0.
- HALT→IDLE when `~start`.

Output behaviour by state:
- IDLE and HALT: `pc_en=0`, `ifid_en=0`, and all three flushes = 1. The pipeline is filled with bubbles.
- DRAIN: `pc_en=0`, `ifid_en=0`, `ifid_flush=1`, `idex_flush=1`, `exmem_flush=0`. Older instructions in EX/MEM/WB complete.
- RUN, branch (`pcsrc=1`):
  - `pc_en=1`, so the PC loads the branch target.
  - `ifid_flush=idex_flush=exmem_flush=1`.
  - Overrides a load-use stall in the same cycle.
- RUN, load-use (`ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2)`):
  - `pc_en=0`, `ifid_en=0`, `idex_flush=1`.
  - Exactly one bubble per hazard. The ForwardingUnit covers the rest.
- RUN, otherwise: `pc_en=1`, `ifid_en=1`, no flush.

Other rules:
- Hazard and flush outputs are combinational from the inputs and the registered state.
- `x0` never causes a stall.
- `rst=1` forces IDLE, clears the drain counter and clears all counters on the next edge, regardless of state. This includes mid-DRAIN and mid-stall.

## Timing
- Reset values: `state_o=00`, `pc_en=0`, `ifid_en=0`, all flushes = 1, all counters = 0.
- Start latency: `start & upg_done_i` sampled at edge N gives RUN and `pc_en=1` from edge N onward. The first fetch advances on edge N+1.
- Branch penalty: 3 cycles. Flushes are asserted in the cycle `pcsrc=1`, so the bubbles appear in IFID/IDEX/EXMEM after that edge.
- Load-use penalty: 1 cycle.
- DRAIN lasts exactly DRAIN_CYCLES cycles unless squashed by `pcsrc`.
- `halt_i` and `pcsrc` in the same RUN cycle: branch wins and the state stays RUN.
- `halt_i` ignored outside RUN.
- `start` held high in HALT: the state stays HALT, with no auto-restart.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments every cycle in RUN or DRAIN.
  - `stall_cnt` increments every RUN cycle with a load-use stall and no branch.
  - `flush_cnt` increments every RUN or DRAIN cycle with `pcsrc=1`.
  - All counters wrap modulo 2^CNT_W and clear on `rst`.
- Not defined: the counter ports remain but are tied to 0, and no counter flops are synthesized.

## Test plan
- Reset/start: hold `rst` for 2 cycles → state 00, `pc_en=0`, flushes 1. Then `start=1`, `upg_done_i=1` → state 01 the next cycle and `pc_en=1`.
- Load-use: `ex_memread=1`, `ex_rd=5`, `id_rs2=5` → for that cycle `pc_en=0`, `ifid_en=0`, `idex_flush=1`. Repeat with `ex_rd=0` → no stall. With PERF_EN, `stall_cnt` goes 0→1.
- Branch vs stall: `pcsrc=1` together with a load-use match → `pc_en=1` and all three flushes = 1. With PERF_EN, `flush_cnt=1` and `stall_cnt` unchanged.
- Halt drain: `halt_i=1` in RUN → DRAIN for 3 cycles with `exmem_flush=0` → HALT (11). Drop `start` → IDLE.
- Wrong-path halt: `halt_i=1` then `pcsrc=1` on the 2nd DRAIN cycle → back to RUN with all flushes 1. Separately, `halt_i` and `pcsrc` in the same cycle → stays RUN.
- Reprogram/reset mid-run:
  - `upg_done_i→0` during RUN → IDLE the next cycle.
  - `rst=1` during DRAIN → IDLE and counters 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing/hazard controller: run/drain/halt FSM, load-use stall, branch squash.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             cpuclk,
    input  logic             rst,
    input  logic             start,
    input  logic             upg_done_i,
    input  logic             halt_i,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             pcsrc,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    logic       load_use;

    assign state_o  = state;
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= 4'd0;
        end else begin
            unique case (state)
                S_IDLE:  if (start && upg_done_i) state <= S_RUN;
                S_RUN: begin
                    // Reprogramming beats halt; a taken branch squashes a halt in the same cycle.
                    if (!upg_done_i) begin
                        state <= S_IDLE;
                    end else if (halt_i && !pcsrc) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (pcsrc)                  state <= S_RUN;
                    else if (drain_cnt == 4'd0) state <= S_HALT;
                    else                        drain_cnt <= drain_cnt - 4'd1;
                end
                S_HALT:  if (!start) state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        unique case (state)
            S_IDLE, S_HALT: ;
            S_DRAIN: exmem_flush = 1'b0;
            S_RUN: begin
                if (pcsrc) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end else if (load_use) begin
                    ifid_flush  = 1'b0;
                    exmem_flush = 1'b0;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_flush  = 1'b0;
                    exmem_flush = 1'b0;
                end
            end
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic active;
    assign active = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (active)                                  cycle_cnt <= cycle_cnt + CNT_ONE;
            if (state == S_RUN && load_use && !pcsrc)    stall_cnt <= stall_cnt + CNT_ONE;
            if (active && pcsrc)                         flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed plan then random traffic against a rule-level model.
module tb_pipe_ctrl;

    localparam int DC = 3;

    logic        cpuclk = 1'b0;
    logic        rst, start, upg_done_i, halt_i, ex_memread, pcsrc;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  state_o;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    pipe_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
        .cpuclk(cpuclk), .rst(rst), .start(start), .upg_done_i(upg_done_i),
        .halt_i(halt_i), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .pcsrc(pcsrc), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 cpuclk = ~cpuclk;

    typedef struct {
        logic [1:0]  st;
        logic [4:0]  ctl;  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}
        logic [31:0] cc, sc, fc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: named states plus "drain cycles remaining".
    localparam int IDLE = 0, RUN = 1, DRAIN = 2, HALT = 3;
    int          m_state = IDLE;
    int          m_left  = 0;
    logic [31:0] m_cc = 0, m_sc = 0, m_fc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic u, input logic h,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic pc);
        exp_t e;
        logic lu;
        @(posedge cpuclk); #1;
        rst = r; start = s; upg_done_i = u; halt_i = h;
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_memread = mr; pcsrc = pc;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        e.st = 2'(m_state);
        e.cc = m_cc; e.sc = m_sc; e.fc = m_fc;
        if (m_state == IDLE || m_state == HALT) e.ctl = 5'b00111;
        else if (m_state == DRAIN)               e.ctl = 5'b00110;
        else if (pc)                             e.ctl = 5'b11111;
        else if (lu)                             e.ctl = 5'b00010;
        else                                     e.ctl = 5'b11000;
        q.push_back(e);
        if (r) begin
            m_state = IDLE; m_left = 0; m_cc = 0; m_sc = 0; m_fc = 0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            if (m_state == RUN || m_state == DRAIN) m_cc++;
            if (m_state == RUN && lu && !pc) m_sc++;
            if ((m_state == RUN || m_state == DRAIN) && pc) m_fc++;
`endif
            case (m_state)
                IDLE:  if (s && u) m_state = RUN;
                RUN:   if (!u) m_state = IDLE;
                       else if (h && !pc) begin m_state = DRAIN; m_left = DC; end
                DRAIN: if (pc) m_state = RUN;
                       else begin m_left--; if (m_left == 0) m_state = HALT; end
                default: if (!s) m_state = IDLE;
            endcase
        end
    endtask

    task automatic idle_step(input logic s, input logic h, input logic pc);
        step(1'b0, s, 1'b1, h, 5'd1, 5'd2, 5'd3, 1'b0, pc);
    endtask

    // Monitor: outputs are settled mid-cycle, compare on the falling edge.
    always @(negedge cpuclk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 32'(state_o), 32'(e.st));
            chk("ctl{pc,ifid_en,ifid_fl,idex_fl,exmem_fl}",
                32'({pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}), 32'(e.ctl));
            chk("cycle_cnt", cycle_cnt, e.cc);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; upg_done_i = 1'b0; halt_i = 1'b0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memread = 1'b0; pcsrc = 1'b0;
        repeat (2) @(posedge cpuclk);
        // Reset, then start
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_step(1, 0, 0);
        idle_step(1, 0, 0);
        // Load-use, x0 no-stall, branch over stall
        step(0, 1, 1, 0, 5'd1, 5'd5, 5'd5, 1, 0);
        step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        step(0, 1, 1, 0, 5'd5, 5'd1, 5'd5, 1, 1);
        idle_step(1, 0, 0);
        // Halt drain, start held in HALT, drop start
        idle_step(1, 1, 0);
        repeat (DC) idle_step(1, 1, 0);
        idle_step(1, 0, 0);
        idle_step(1, 0, 0);
        idle_step(0, 0, 0);
        idle_step(1, 0, 0);
        // Wrong-path halt squashed on 2nd DRAIN cycle; halt+branch same cycle
        idle_step(1, 1, 0);
        idle_step(1, 0, 0);
        idle_step(1, 0, 1);
        idle_step(1, 1, 1);
        idle_step(1, 0, 0);
        // Reprogram mid-run, then reset mid-drain
        step(0, 1, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0);
        idle_step(1, 0, 0);
        idle_step(1, 1, 0);
        idle_step(1, 0, 0);
        step(1, 1, 1, 0, 5'd1, 5'd2, 5'd3, 0, 0);
        idle_step(1, 0, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) != 0), ($urandom_range(0, 7) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge cpuclk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
